// File: rtl/task_join_pkg.sv
// Shared types and constants for the fork/join dispatch controller.
package task_join_pkg;

    localparam int JOIN_MODE_W = 2;

    typedef enum logic [JOIN_MODE_W-1:0] {
        JM_ALL  = 2'd0,
        JM_ANY  = 2'd1,
        JM_NONE = 2'd2,
        JM_RSVD = 2'd3
    } join_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RESP   = 3'd3,
        ST_DRAIN  = 3'd4
    } state_e;

endpackage

// File: rtl/task_join_ctrl_timer.sv
// Saturating elapsed-cycle counter with clear, enable and a limit compare.
// Clear and enable together load the value 1 (clear first, then count).
module join_timer #(
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [TMO_W-1:0] limit,
    output logic [TMO_W-1:0] count,
    output logic             hit
);

    localparam logic [TMO_W-1:0] ONE = TMO_W'(1);

    logic [TMO_W-1:0] count_q;
    logic [TMO_W-1:0] count_d;
    logic [TMO_W-1:0] base;

    // Next count: optional clear, then a saturating increment when enabled.
    always_comb begin
        base    = clear ? '0 : count_q;
        count_d = base;
        if (enable && (base != '1)) begin
            count_d = base + ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign hit   = (limit != '0) && (count_q == limit);

endmodule

// File: rtl/task_join_ctrl.sv
// Fork/join dispatch controller: launches a set of worker channels, collects
// their done pulses and reports completion under an ALL/ANY/NONE join policy.
module task_join_ctrl
    import task_join_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int TMO_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fork_valid,
    output logic                   fork_ready,
    input  logic [NUM_CH-1:0]      fork_mask,
    input  logic [JOIN_MODE_W-1:0] join_mode,
    input  logic [TMO_W-1:0]       timeout,
    output logic [NUM_CH-1:0]      ch_start,
    input  logic [NUM_CH-1:0]      ch_done,
    output logic                   join_valid,
    input  logic                   join_ready,
    output logic [NUM_CH-1:0]      join_status,
    output logic                   join_timeout,
    output logic [TMO_W-1:0]       join_cycles,
    output logic                   busy
);

    state_e            state_q, state_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    join_mode_e        mode_q, mode_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [NUM_CH-1:0] done_mask_q, done_mask_d;
    logic [NUM_CH-1:0] status_q, status_d;
    logic [TMO_W-1:0]  cycles_q, cycles_d;
    logic              timed_out_q, timed_out_d;

    logic              tmr_clear;
    logic              tmr_enable;
    logic [TMO_W-1:0]  tmr_count;
    logic              tmr_hit;
    logic              join_met;

    join_timer #(
        .TMO_W (TMO_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .limit  (tmo_q),
        .count  (tmr_count),
        .hit    (tmr_hit)
    );

    // Next-state, done accumulation and join-point capture.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        mode_d      = mode_q;
        tmo_d       = tmo_q;
        done_mask_d = done_mask_q;
        status_d    = status_q;
        cycles_d    = cycles_q;
        timed_out_d = timed_out_q;
        tmr_clear   = 1'b0;
        tmr_enable  = 1'b0;
        join_met    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fork_valid) begin
                    mask_d      = fork_mask;
                    mode_d      = join_mode_e'(join_mode);
                    tmo_d       = timeout;
                    done_mask_d = '0;
                    tmr_clear   = 1'b1;
                    tmr_enable  = 1'b1;
                    state_d     = ST_LAUNCH;
                end
            end

            ST_LAUNCH: begin
                tmr_enable = 1'b1;
                if ((mask_q == '0) || (mode_q == JM_NONE)) begin
                    status_d    = done_mask_q;
                    cycles_d    = tmr_count;
                    timed_out_d = 1'b0;
                    state_d     = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                tmr_enable  = 1'b1;
                done_mask_d = done_mask_q | (ch_done & mask_q);
                join_met    = (mode_q == JM_ANY) ? (done_mask_d != '0)
                                                 : (done_mask_d == mask_q);
                if (join_met) begin
                    status_d    = done_mask_d;
                    cycles_d    = tmr_count;
                    timed_out_d = 1'b0;
                    state_d     = ST_RESP;
                end else if (tmr_hit) begin
                    status_d    = done_mask_d;
                    cycles_d    = tmr_count;
                    timed_out_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end

            ST_RESP: begin
                done_mask_d = done_mask_q | (ch_done & mask_q);
                if (join_ready) begin
                    if (timed_out_q || (done_mask_d == mask_q)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                done_mask_d = done_mask_q | (ch_done & mask_q);
                if (done_mask_d == mask_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            mode_q      <= JM_ALL;
            tmo_q       <= '0;
            done_mask_q <= '0;
            status_q    <= '0;
            cycles_q    <= '0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            mode_q      <= mode_d;
            tmo_q       <= tmo_d;
            done_mask_q <= done_mask_d;
            status_q    <= status_d;
            cycles_q    <= cycles_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign fork_ready   = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign join_valid   = (state_q == ST_RESP);
    assign ch_start     = (state_q == ST_LAUNCH) ? mask_q : '0;
    assign join_status  = status_q;
    assign join_cycles  = cycles_q;
    assign join_timeout = timed_out_q;

endmodule

// File: tb/tb_task_join_ctrl.sv
// Scoreboard bench for task_join_ctrl: the driver predicts each join result
// from the policy rules and queues it; a negedge monitor pops and compares.
module tb_task_join_ctrl;

   localparam int NUM_CH = 3;
   localparam int TMO_W  = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              fork_valid = 1'b0;
   logic              fork_ready;
   logic [NUM_CH-1:0] fork_mask = '0;
   logic [1:0]        join_mode = '0;
   logic [TMO_W-1:0]  timeout = '0;
   logic [NUM_CH-1:0] ch_start;
   logic [NUM_CH-1:0] ch_done = '0;
   logic              join_valid;
   logic              join_ready = 1'b0;
   logic [NUM_CH-1:0] join_status;
   logic              join_timeout;
   logic [TMO_W-1:0]  join_cycles;
   logic              busy;

   int nCompared = 0;
   int nMismatched = 0;
   int cyc = 0;

   typedef struct {
      logic [NUM_CH-1:0] status;
      int                cycles;
      bit                tmo;
      int                arrive;
   } exp_t;

   exp_t expQ[$];

   task_join_ctrl #(
      .NUM_CH (NUM_CH),
      .TMO_W  (TMO_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fork_valid   (fork_valid),
      .fork_ready   (fork_ready),
      .fork_mask    (fork_mask),
      .join_mode    (join_mode),
      .timeout      (timeout),
      .ch_start     (ch_start),
      .ch_done      (ch_done),
      .join_valid   (join_valid),
      .join_ready   (join_ready),
      .join_status  (join_status),
      .join_timeout (join_timeout),
      .join_cycles  (join_cycles),
      .busy         (busy)
   );

   // Free-running clock and a cycle index shared by driver and monitor.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // One comparison: count it and report a failure with both values.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Monitor: pops the predicted result when join_valid rises and checks it
   // stays frozen for as long as the result is presented.
   exp_t cur;
   bit   haveCur = 0;
   bit   prevValid = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prevValid = 0;
         haveCur = 0;
      end else begin
         if (join_valid && !prevValid) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_join_valid", 32'd1, 32'd0);
               haveCur = 0;
            end else begin
               cur = expQ.pop_front();
               haveCur = 1;
               checkOutput("join_arrival_cycle", cyc, cur.arrive);
               checkOutput("join_status", {29'd0, join_status}, {29'd0, cur.status});
               checkOutput("join_cycles", {16'd0, join_cycles}, cur.cycles);
               checkOutput("join_timeout", {31'd0, join_timeout}, {31'd0, cur.tmo});
            end
         end else if (join_valid && haveCur) begin
            checkOutput("held_status", {29'd0, join_status}, {29'd0, cur.status});
            checkOutput("held_cycles", {16'd0, join_cycles}, cur.cycles);
            checkOutput("held_timeout", {31'd0, join_timeout}, {31'd0, cur.tmo});
         end
         prevValid = join_valid;
      end
   end

   // Reset the DUT and forget any predictions still queued.
   task automatic pulseReset();
      @(negedge clk);
      rst_n = 1'b0;
      fork_valid = 1'b0;
      ch_done = '0;
      join_ready = 1'b0;
      expQ.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Run one fork: predict the join from the policy rules, then drive done
   // pulses at the given launch-relative cycles with random backpressure.
   task automatic applyStimulus(input logic [2:0] m, input int mode, input int tmo,
                                input int d0, input int d1, input int d2,
                                input int readyPct, input bit poke);
      int d[3];
      int jt, cycE, tJoin, maxd, launchCyc, t, h, idleT;
      logic [2:0] st;
      logic [2:0] nd;
      bit to;
      bit expired;
      exp_t e;

      d[0] = d0; d[1] = d1; d[2] = d2;
      maxd = 0;
      for (int i = 0; i < NUM_CH; i++)
         if (m[i] && d[i] > maxd) maxd = d[i];

      st = '0;
      to = 0;
      if (m == 3'b000 || mode == 2) begin
         jt = 0;
         cycE = 1;
      end else begin
         tJoin = (mode == 1) ? 1000000 : 0;
         for (int i = 0; i < NUM_CH; i++) begin
            if (m[i]) begin
               if (mode == 1) tJoin = (d[i] < tJoin) ? d[i] : tJoin;
               else           tJoin = (d[i] > tJoin) ? d[i] : tJoin;
            end
         end
         if (tmo != 0 && tmo - 1 < tJoin) begin
            jt = tmo - 1;
            cycE = tmo;
            to = 1;
         end else begin
            jt = tJoin;
            cycE = tJoin + 1;
         end
         for (int i = 0; i < NUM_CH; i++)
            if (m[i] && d[i] <= jt) st[i] = 1'b1;
      end

      fork_mask = m;
      join_mode = mode[1:0];
      timeout = tmo[15:0];
      fork_valid = 1'b1;
      @(posedge clk); #1;
      fork_valid = 1'b0;
      launchCyc = cyc;
      checkOutput("ch_start_launch", {29'd0, ch_start}, {29'd0, m});
      e.status = st;
      e.cycles = cycE;
      e.tmo = to;
      e.arrive = launchCyc + jt + 1;
      expQ.push_back(e);

      h = -1;
      idleT = -1;
      expired = 0;
      while (1) begin
         @(posedge clk); #1;
         t = cyc - launchCyc;
         nd = '0;
         for (int i = 0; i < NUM_CH; i++)
            if (m[i] && d[i] == t) nd[i] = 1'b1;
         if ($urandom_range(0, 5) == 0) nd = nd | (3'($urandom) & ~m);
         ch_done = nd;
         join_ready = ($urandom_range(1, 100) <= readyPct);
         fork_valid = poke && (h >= 0) && (t > h) && (t < idleT - 1);
         if (h < 0 && join_valid && join_ready) begin
            h = t;
            idleT = to ? h + 1 : (((maxd > h) ? maxd : h) + 1);
         end
         if (h >= 0) begin
            if (t == idleT - 1) checkOutput("busy_before_idle", {31'd0, busy}, 32'd1);
            if (t == idleT) begin
               checkOutput("fork_ready_at_idle", {31'd0, fork_ready}, 32'd1);
               checkOutput("busy_at_idle", {31'd0, busy}, 32'd0);
            end
            if (poke && t > h + 1 && t < idleT)
               checkOutput("ch_start_in_drain", {29'd0, ch_start}, 32'd0);
            if (t >= idleT && t > maxd) break;
         end
         if (t > maxd + 300) begin
            checkOutput("handshake_within_budget", 32'd0, 32'd1);
            expired = 1;
            break;
         end
      end
      ch_done = '0;
      join_ready = 1'b0;
      fork_valid = 1'b0;
      if (expired) begin
         pulseReset();
      end else begin
         checkOutput("fork_ready_end", {31'd0, fork_ready}, 32'd1);
         checkOutput("response_consumed", expQ.size(), 32'd0);
      end
   endtask

   // Reset asserted while waiting on workers: outputs clear at once.
   task automatic applyMidReset();
      fork_mask = 3'b011;
      join_mode = 2'd0;
      timeout = '0;
      fork_valid = 1'b1;
      @(posedge clk); #1;
      fork_valid = 1'b0;
      checkOutput("rst_test_launch", {29'd0, ch_start}, 32'd3);
      repeat (5) begin
         @(posedge clk); #1;
      end
      ch_done = 3'b001;
      @(posedge clk); #1;
      ch_done = '0;
      checkOutput("rst_test_busy_in_wait", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_async_fork_ready", {31'd0, fork_ready}, 32'd1);
      checkOutput("rst_async_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_async_join_valid", {31'd0, join_valid}, 32'd0);
      checkOutput("rst_async_ch_start", {29'd0, ch_start}, 32'd0);
      checkOutput("rst_async_status", {29'd0, join_status}, 32'd0);
      @(posedge clk); #1;
      checkOutput("rst_hold_ch_start", {29'd0, ch_start}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Main sequence: reset values, directed policy cases, mid-run reset,
   // then randomized forks.
   initial begin
      logic [2:0] m;
      int mode, tmo;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_fork_ready", {31'd0, fork_ready}, 32'd1);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_join_valid", {31'd0, join_valid}, 32'd0);
      checkOutput("reset_ch_start", {29'd0, ch_start}, 32'd0);
      checkOutput("reset_join_status", {29'd0, join_status}, 32'd0);
      checkOutput("reset_join_cycles", {16'd0, join_cycles}, 32'd0);
      checkOutput("reset_join_timeout", {31'd0, join_timeout}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(3'b011, 0, 0, 30, 40, 0, 100, 0);
      applyStimulus(3'b011, 2, 0, 30, 40, 0, 100, 0);
      applyStimulus(3'b111, 1, 0, 30, 45, 50, 100, 1);
      applyStimulus(3'b100, 0, 20, 0, 0, 50, 60, 0);
      applyStimulus(3'b000, 0, 0, 0, 0, 0, 100, 0);
      applyStimulus(3'b001, 0, 0, 25, 0, 0, 100, 0);
      applyStimulus(3'b001, 0, 10, 9, 0, 0, 100, 0);
      applyStimulus(3'b010, 3, 0, 0, 12, 0, 50, 0);

      applyMidReset();
      applyStimulus(3'b011, 0, 0, 3, 7, 0, 100, 0);

      for (int n = 0; n < 40; n++) begin
         m = 3'($urandom_range(0, 7));
         mode = $urandom_range(0, 3);
         tmo = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 40) : 0;
         applyStimulus(m, mode, tmo,
                       $urandom_range(1, 40), $urandom_range(1, 40), $urandom_range(1, 40),
                       $urandom_range(30, 100), 0);
      end

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
